// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between a data-memory requester and data_mem_responder
interface data_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              fault;
    modport master (output mem_en, mem_wen, addr, wdata, input rdata, ready, busy, fault);
    modport slave (input mem_en, mem_wen, addr, wdata, output rdata, ready, busy, fault);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated word RAM serving one request at a time with a one-cycle ready pulse
// MEM_FAULT_EN enables out-of-range detection and the fault pulse; otherwise addresses wrap mod DEPTH
module data_mem_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 1
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
    state_t            state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_q;
    logic              bad_q;
    logic              oor;
    logic [DATA_W-1:0] ram [DEPTH];
`ifdef MEM_FAULT_EN
    assign oor = 32'(bus.addr) >= DEPTH;
`else
    assign oor = 1'b0;
`endif
    // Reset on the commit edge still aborts the write.
    always_ff @(posedge clk)
        if (!reset && state == S_ACCESS && wen_q && !bad_q) ram[idx_q] <= wdata_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            bad_q     <= 1'b0;
            bus.rdata <= '0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b0;
            bus.fault <= 1'b0;
        end else begin
            bus.ready <= state == S_ACCESS;
            bus.fault <= state == S_ACCESS && bad_q;
            case (state)
                S_IDLE: if (bus.mem_en) begin
                    idx_q    <= IDX_W'(32'(bus.addr) % DEPTH);
                    wdata_q  <= bus.wdata;
                    wen_q    <= bus.mem_wen;
                    bad_q    <= oor;
                    cnt      <= 4'(WAIT_CYC);
                    state    <= WAIT_CYC == 0 ? S_ACCESS : S_WAIT;
                    bus.busy <= 1'b1;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!wen_q && !bad_q) bus.rdata <= ram[idx_q];
                    state <= S_RESP;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
